// File: rtl/hs400_idly_sweep_tuner.sv
`default_nettype none
//------------------------------------------------------------------------------
// hs400_idly_sweep_tuner - sweeps DS IDELAY taps, centres on the widest eye | rev 1.0
//------------------------------------------------------------------------------
module hs400_idly_sweep_tuner #(
    parameter int              TAP_W       = 5,
    parameter int              DS_W        = 2,
    parameter logic [DS_W-1:0] EXP_PAT     = 2'b01,
    parameter int              SETTLE_CYC  = 8,
    parameter int              SAMPLES     = 16,
    parameter int              MIN_EYE     = 4,
    parameter int              DEFAULT_TAP = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             idly_tuning_start,
    output logic             idly_tuning_ready,
    output logic             idly_tuning_done,
    output logic             idly_tuning_failed,
    input  logic [23:0]      idly_tuning_timeout,
    input  logic [DS_W-1:0]  data_strobe,
    output logic [TAP_W-1:0] cntval_in,
    output logic             cntval_load,
    input  logic [TAP_W-1:0] cntval_out,
    output logic [TAP_W-1:0] tuned_tap,
    output logic [TAP_W:0]   eye_width
);
    localparam int               CNT_MAX     = (SETTLE_CYC > SAMPLES) ? SETTLE_CYC : SAMPLES;
    localparam int               CNT_W       = $clog2(CNT_MAX + 1);
    localparam logic [TAP_W-1:0] LAST_TAP    = {TAP_W{1'b1}};
    localparam logic [TAP_W-1:0] DEF_TAP     = TAP_W'(DEFAULT_TAP);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(SAMPLES - 1);
    localparam logic [TAP_W:0]   MIN_LEN     = (TAP_W+1)'(MIN_EYE);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_LOAD   = 4'd1,
        S_SETTLE = 4'd2,
        S_SAMPLE = 4'd3,
        S_EVAL   = 4'd4,
        S_CENTER = 4'd5,
        S_VERIFY = 4'd6,
        S_DONE   = 4'd7,
        S_FAIL   = 4'd8
    } state_t;

    state_t           state, state_nxt;
    logic [TAP_W-1:0] tap, tap_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [23:0]      timer, timer_nxt;
    logic             pass, pass_nxt;
    logic [TAP_W-1:0] run_start, run_start_nxt, best_start, best_start_nxt;
    logic [TAP_W:0]   run_len, run_len_nxt, best_len, best_len_nxt;
    logic             done_nxt, failed_nxt, load_nxt, go_fail;
    logic [TAP_W-1:0] tap_out_nxt, tuned_nxt, center_tap;
    logic [TAP_W:0]   eye_nxt;
    logic [24:0]      elapsed;
    logic             busy, timeout_hit;

    assign idly_tuning_ready = (state == S_IDLE) || (state == S_DONE) || (state == S_FAIL);
    assign busy              = !idly_tuning_ready;
    assign center_tap        = best_start + TAP_W'((best_len - (TAP_W+1)'(1)) >> 1);
    // elapsed includes the cycle in which start was accepted
    assign elapsed           = {1'b0, timer} + 25'd2;
    assign timeout_hit       = busy && (idly_tuning_timeout != 24'd0) &&
                               (elapsed >= {1'b0, idly_tuning_timeout});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state              <= S_IDLE;
            tap                <= '0;
            cnt                <= '0;
            timer              <= '0;
            pass               <= 1'b0;
            run_start          <= '0;
            run_len            <= '0;
            best_start         <= '0;
            best_len           <= '0;
            idly_tuning_done   <= 1'b0;
            idly_tuning_failed <= 1'b0;
            cntval_in          <= DEF_TAP;
            cntval_load        <= 1'b0;
            tuned_tap          <= '0;
            eye_width          <= '0;
        end else begin
            state              <= state_nxt;
            tap                <= tap_nxt;
            cnt                <= cnt_nxt;
            timer              <= timer_nxt;
            pass               <= pass_nxt;
            run_start          <= run_start_nxt;
            run_len            <= run_len_nxt;
            best_start         <= best_start_nxt;
            best_len           <= best_len_nxt;
            idly_tuning_done   <= done_nxt;
            idly_tuning_failed <= failed_nxt;
            cntval_in          <= tap_out_nxt;
            cntval_load        <= load_nxt;
            tuned_tap          <= tuned_nxt;
            eye_width          <= eye_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        tap_nxt        = tap;
        cnt_nxt        = cnt;
        timer_nxt      = timer;
        pass_nxt       = pass;
        run_start_nxt  = run_start;
        run_len_nxt    = run_len;
        best_start_nxt = best_start;
        best_len_nxt   = best_len;
        done_nxt       = idly_tuning_done;
        failed_nxt     = idly_tuning_failed;
        tap_out_nxt    = cntval_in;
        load_nxt       = 1'b0;
        tuned_nxt      = tuned_tap;
        eye_nxt        = eye_width;
        go_fail        = 1'b0;

        if (busy) begin
            timer_nxt = timer + 24'd1;
        end

        case (state)
            S_IDLE, S_DONE, S_FAIL: begin
                if (idly_tuning_start) begin
                    done_nxt       = 1'b0;
                    failed_nxt     = 1'b0;
                    tap_nxt        = '0;
                    cnt_nxt        = '0;
                    timer_nxt      = '0;
                    pass_nxt       = 1'b0;
                    run_start_nxt  = '0;
                    run_len_nxt    = '0;
                    best_start_nxt = '0;
                    best_len_nxt   = '0;
                    tap_out_nxt    = '0;
                    load_nxt       = 1'b1;
                    state_nxt      = S_LOAD;
                end
            end
            S_LOAD: begin
                cnt_nxt   = '0;
                state_nxt = S_SETTLE;
            end
            S_SETTLE: begin
                if (cnt == SETTLE_LAST) begin
                    cnt_nxt   = '0;
                    pass_nxt  = 1'b1;
                    state_nxt = S_SAMPLE;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            S_SAMPLE: begin
                if (data_strobe != EXP_PAT) begin
                    pass_nxt = 1'b0;
                end
                if (cnt == SAMPLE_LAST) begin
                    state_nxt = S_EVAL;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            S_EVAL: begin
                if (pass) begin
                    run_len_nxt = run_len + (TAP_W+1)'(1);
                    if (run_len == '0) begin
                        run_start_nxt = tap;
                    end
                end else begin
                    run_len_nxt = '0;
                end
                // strictly longer only, so the earlier of two equal eyes is kept
                if (run_len_nxt > best_len) begin
                    best_len_nxt   = run_len_nxt;
                    best_start_nxt = run_start_nxt;
                end
                if (tap == LAST_TAP) begin
                    state_nxt = S_CENTER;
                end else begin
                    tap_nxt     = tap + TAP_W'(1);
                    tap_out_nxt = tap + TAP_W'(1);
                    load_nxt    = 1'b1;
                    state_nxt   = S_LOAD;
                end
            end
            S_CENTER: begin
                eye_nxt = best_len;
                if (best_len < MIN_LEN) begin
                    go_fail = 1'b1;
                end else begin
                    tuned_nxt   = center_tap;
                    tap_out_nxt = center_tap;
                    load_nxt    = 1'b1;
                    cnt_nxt     = '0;
                    state_nxt   = S_VERIFY;
                end
            end
            S_VERIFY: begin
                if (cnt == SETTLE_LAST) begin
                    if (cntval_out == tuned_tap) begin
                        done_nxt  = 1'b1;
                        state_nxt = S_DONE;
                    end else begin
                        go_fail = 1'b1;
                    end
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        if (timeout_hit) begin
            go_fail   = 1'b1;
            done_nxt  = 1'b0;
            tuned_nxt = tuned_tap;
            eye_nxt   = eye_width;
        end

        if (go_fail) begin
            state_nxt   = S_FAIL;
            failed_nxt  = 1'b1;
            tap_out_nxt = DEF_TAP;
            load_nxt    = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hs400_idly_sweep_tuner.sv
`default_nettype none
// Bench for hs400_idly_sweep_tuner: an IDELAY/strobe model feeds the tuner and a
// tap-map eye model predicts outcome, latency and load-pulse count of each run.
module tb_hs400_idly_sweep_tuner;
    localparam int         TAP_W       = 5;
    localparam int         DS_W        = 2;
    localparam int         SETTLE_CYC  = 8;
    localparam int         SAMPLES     = 16;
    localparam int         MIN_EYE     = 4;
    localparam int         DEFAULT_TAP = 0;
    localparam logic [1:0] EXP_PAT     = 2'b01;
    localparam int         NTAP        = 1 << TAP_W;
    localparam int         PER_TAP     = SETTLE_CYC + SAMPLES + 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             ready, done, failed;
    logic [23:0]      timeout;
    logic [DS_W-1:0]  data_strobe;
    logic [TAP_W-1:0] cntval_in, cntval_out, tuned_tap;
    logic             cntval_load;
    logic [TAP_W:0]   eye_width;

    bit               pass_map [NTAP];
    logic [TAP_W-1:0] idly_tap;
    logic             tie_zero;
    logic [1:0]       rnd = 2'd0;
    int               load_cnt = 0;
    int               n_checks = 0;
    int               n_errors = 0;
    int               prev_tuned = 0;
    int               prev_eye = 0;

    hs400_idly_sweep_tuner #(
        .TAP_W(TAP_W), .DS_W(DS_W), .EXP_PAT(EXP_PAT), .SETTLE_CYC(SETTLE_CYC),
        .SAMPLES(SAMPLES), .MIN_EYE(MIN_EYE), .DEFAULT_TAP(DEFAULT_TAP)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .idly_tuning_start   (start),
        .idly_tuning_ready   (ready),
        .idly_tuning_done    (done),
        .idly_tuning_failed  (failed),
        .idly_tuning_timeout (timeout),
        .data_strobe         (data_strobe),
        .cntval_in           (cntval_in),
        .cntval_load         (cntval_load),
        .cntval_out          (cntval_out),
        .tuned_tap           (tuned_tap),
        .eye_width           (eye_width)
    );

    always #5 clk = ~clk;

    // IDELAY model: tap latches on the load strobe
    always @(posedge clk or posedge rst) begin
        if (rst) idly_tap <= TAP_W'(DEFAULT_TAP);
        else if (cntval_load) idly_tap <= cntval_in;
    end

    always @(posedge clk) begin
        rnd <= 2'($urandom_range(0, 2));
        if (cntval_load) load_cnt <= load_cnt + 1;
    end

    assign cntval_out  = tie_zero ? '0 : idly_tap;
    assign data_strobe = pass_map[idly_tap] ? EXP_PAT :
                         (rnd == 2'd0) ? 2'b00 : (rnd == 2'd1) ? 2'b10 : 2'b11;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_map();
        for (int i = 0; i < NTAP; i++) pass_map[i] = 1'b0;
    endtask

    task automatic set_range(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) pass_map[i] = 1'b1;
    endtask

    // longest run of passing taps, earliest one on ties
    function automatic void eye_model(output int bs, output int bl);
        bs = 0;
        bl = 0;
        for (int s = 0; s < NTAP; s++) begin
            int l;
            l = 0;
            while (s + l < NTAP && pass_map[s + l]) l++;
            if (l > bl) begin
                bl = l;
                bs = s;
            end
        end
    endfunction

    task automatic run_case(input string name, input int to, input bit tz, input int poke_at);
        int bs, bl, center, lat, lat_norm, n, loads0, exp_loads;
        bit fail_eye, verify_ok, timed, exp_done;
        eye_model(bs, bl);
        center    = bs + ((bl - 1) >>> 1);
        fail_eye  = bl < MIN_EYE;
        verify_ok = !tz || center == 0;
        lat_norm  = NTAP * PER_TAP + 2 + (fail_eye ? 0 : SETTLE_CYC);
        timed     = to != 0 && to <= lat_norm;
        lat       = timed ? to : lat_norm;
        exp_done  = !timed && !fail_eye && verify_ok;
        if (timed) begin
            exp_loads = 1;
            for (int k = 0; k < NTAP; k++)
                if (k * PER_TAP + 1 <= to - 1) exp_loads++;
        end else begin
            exp_loads = NTAP + 1 + ((!fail_eye && !verify_ok) ? 1 : 0);
        end

        @(negedge clk);
        tie_zero = tz;
        timeout  = 24'(to);
        start    = 1'b1;
        loads0   = load_cnt;
        @(posedge clk);
        #1;
        start = 1'b0;
        n = 1;
        check({name, ":accepted"}, int'(ready), 0);
        while (ready !== 1'b1 && n < 3000) begin
            start = (n == poke_at);
            @(posedge clk);
            #1;
            n++;
        end
        start = 1'b0;
        check({name, ":latency"}, n, lat);
        check({name, ":done"}, int'(done), int'(exp_done));
        check({name, ":failed"}, int'(failed), int'(!exp_done));
        check({name, ":flags_excl"}, int'(done & failed), 0);
        if (!timed && !fail_eye) begin
            prev_tuned = center;
        end
        if (!timed) begin
            prev_eye = bl;
        end
        check({name, ":tuned_tap"}, int'(tuned_tap), prev_tuned);
        check({name, ":eye_width"}, int'(eye_width), prev_eye);
        @(posedge clk);
        #1;
        check({name, ":cntval_in"}, int'(cntval_in), exp_done ? center : DEFAULT_TAP);
        check({name, ":load_idle"}, int'(cntval_load), 0);
        check({name, ":load_pulses"}, load_cnt - loads0, exp_loads);
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        timeout  = '0;
        tie_zero = 1'b0;
        clear_map();
        repeat (3) @(posedge clk);
        #1;
        check("rst:ready", int'(ready), 1);
        check("rst:done", int'(done), 0);
        check("rst:failed", int'(failed), 0);
        check("rst:cntval_in", int'(cntval_in), DEFAULT_TAP);
        check("rst:load", int'(cntval_load), 0);
        check("rst:tuned", int'(tuned_tap), 0);
        check("rst:eye", int'(eye_width), 0);
        @(negedge clk);
        rst = 1'b0;

        clear_map(); set_range(10, 17);
        run_case("eye10_17", 0, 1'b0, 0);
        clear_map(); set_range(3, 8); set_range(20, 25);
        run_case("two_eyes_busy_start", 0, 1'b0, 300);
        clear_map(); set_range(0, 2);
        run_case("narrow", 0, 1'b0, 0);
        clear_map(); set_range(26, 31);
        run_case("top_edge", 0, 1'b0, 0);
        clear_map(); set_range(0, NTAP - 1);
        run_case("timeout100", 100, 1'b0, 0);
        run_case("all_pass", 0, 1'b0, 0);
        clear_map(); set_range(10, 17);
        run_case("readback0", 0, 1'b1, 0);

        // reset in the middle of tap 0 sampling
        @(negedge clk);
        timeout = '0;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        check("midrst:busy", int'(ready), 0);
        rst = 1'b1;
        #1;
        check("midrst:ready", int'(ready), 1);
        check("midrst:done", int'(done), 0);
        check("midrst:failed", int'(failed), 0);
        check("midrst:cntval_in", int'(cntval_in), DEFAULT_TAP);
        check("midrst:load", int'(cntval_load), 0);
        check("midrst:tuned", int'(tuned_tap), 0);
        @(negedge clk);
        rst = 1'b0;
        prev_tuned = 0;
        prev_eye   = 0;

        for (int r = 0; r < 6; r++) begin
            int nseg, lo, len, hi, to, poke;
            bit tz;
            clear_map();
            nseg = $urandom_range(1, 3);
            for (int s = 0; s < nseg; s++) begin
                lo  = $urandom_range(0, NTAP - 1);
                len = $urandom_range(1, 12);
                hi  = (lo + len - 1 > NTAP - 1) ? NTAP - 1 : lo + len - 1;
                set_range(lo, hi);
            end
            to   = ($urandom_range(0, 3) == 0) ? 5000 : 0;
            tz   = ($urandom_range(0, 4) == 0);
            poke = ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, 800)) : 0;
            run_case("random", to, tz, poke);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
